fm_modulate: RTL and testbench
==============================

Name: fm_modulate

Overview:
- FM modulator: the transmit-side counterpart of the angle-differencing FM demodulator.
- Takes signed audio samples on an AXI-Stream slave and scales each by a runtime deviation gain to form a phase increment.
- Integrates the increments into a wrapping 16-bit phase accumulator.
- Emits {angle, magnitude} beats on an AXI-Stream master, in the packing the CORDIC/demod path consumes: [31:16] angle, [15:0] magnitude.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, slave tdata width; only [15:0] is used.
- C_M00_AXIS_TDATA_WIDTH, 32, master tdata width.
- MAGNITUDE, 16'h4000, constant unsigned magnitude placed in m00_axis_tdata[15:0].
- CLEAR_ON_LAST, 1, when 1 the phase accumulator returns to 0 after a beat with tlast is emitted.

Ports:
- s00_axis_aclk, in, 1: the single clock.
- s00_axis_aresetn, in, 1: synchronous, active-high reset (1 = reset, sampled on the s00_axis_aclk rising edge).
- gain, in, 16: unsigned Q8.8 deviation gain (0x0100 = 1.0).
- s00_axis_tvalid, in, 1: input sample valid.
- s00_axis_tlast, in, 1: end of packet.
- s00_axis_tdata, in, C_S00_AXIS_TDATA_WIDTH: [15:0] signed two's-complement sample; upper bits ignored.
- s00_axis_tstrb, in, C_S00_AXIS_TDATA_WIDTH/8: ignored.
- s00_axis_tready, out, 1: sample accepted when tvalid && tready.
- m00_axis_tready, in, 1: downstream ready.
- m00_axis_tvalid, out, 1: output beat valid.
- m00_axis_tlast, out, 1: tlast of the source sample.
- m00_axis_tdata, out, C_M00_AXIS_TDATA_WIDTH: [31:16] angle (phase), [15:0] MAGNITUDE.
- m00_axis_tstrb, out, C_M00_AXIS_TDATA_WIDTH/8: constant all ones.

Behaviour:
- Reset (synchronous, high):
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
  - Phase accumulator=0; all stage valid flags=0.
  - Reset overrides any handshake in the same cycle; a mid-packet reset discards in-flight beats.
- Pipeline enable: en = m00_axis_tready || !m00_axis_tvalid. s00_axis_tready = en, combinational. The whole pipeline advances only when en=1; when en=0 every stage register holds.
- Stage 1 (on en):
  - p1_valid <= s00_axis_tvalid.
  - On accept, p1_prod <= signed(sample) * signed({1'b0,gain}), 33-bit.
  - p1_last <= s00_axis_tlast.
  - gain is sampled only at accept; changing it affects subsequent beats only.
- Increment: inc = p1_prod[23:8], i.e. arithmetic >>>8 (floor toward -inf) truncated to 16 bits. Overflow beyond 16 bits wraps silently.
- Stage 2 (on en, when p1_valid):
  - phase_next = phase + inc, mod 2^16.
  - m00_axis_tdata <= {phase_next, MAGNITUDE}; m00_axis_tlast <= p1_last; m00_axis_tvalid <= 1.
  - phase <= (CLEAR_ON_LAST && p1_last) ? 0 : phase_next.
- Stage 2 (on en, when !p1_valid): m00_axis_tvalid <= 0.
- Latency: an accepted sample appears on the master 2 cycles after acceptance when not stalled. Throughput is 1 beat/cycle.
- The first output after reset or after a cleared tlast carries angle = inc of that sample (phase starts at 0).
- Backpressure: while m00_axis_tvalid && !m00_axis_tready, the output holds tdata/tlast stable and s00_axis_tready=0. No beat is dropped or duplicated.
- Bubbles (s00_axis_tvalid=0) propagate as tvalid=0 and do not change phase.
- Wrap-around: phase rolls over 0xFFFF->0x0000 and below 0 with no saturation.
- Simultaneous input accept and output handshake in one cycle is normal streaming operation.

Test Plan:
- Reset: hold s00_axis_aresetn=1 for 3 cycles with random inputs -> m00_axis_tvalid=0, m00_axis_tdata=0; first output after release has angle = first inc.
- Ramp: gain=0x0100, samples 100,100,100 back-to-back, m00_axis_tready=1 -> m00_axis_tdata 0x0064_4000, 0x00C8_4000, 0x012C_4000 on consecutive cycles, first one 2 cycles after first accept.
- Wrap: gain=0x0100, samples 0x7FFF, 0x7FFF, 3 -> angles 0x7FFF, 0xFFFE, 0x0001.
- Negative/fractional gain: gain=0x0080, sample -3 (0xFFFD) -> inc = -2, angle 0xFFFE; then sample 3 -> inc = 1, angle 0xFFFF.
- Backpressure: stream 1..8 with gain=0x0100; drop m00_axis_tready for 3 cycles mid-stream -> s00_axis_tready=0 throughout, tdata stable, emitted angles are exactly the prefix sums 1,3,6,10,15,21,28,36.
- tlast/clear: CLEAR_ON_LAST=1, gain=0x0100, samples 10, 10(tlast), 10 -> angles 10, 20 (m00_axis_tlast=1), 10. Assert reset mid-packet -> next packet restarts from phase 0.

Source files
------------

// File: rtl/fm_modulate.sv
// FM modulator: scales signed audio samples by a Q8.8 deviation gain and integrates them
// into a wrapping 16-bit phase, emitted as {angle, magnitude} AXI-Stream beats.
module fm_modulate #(
   parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
   parameter logic [15:0] MAGNITUDE              = 16'h4000,
   parameter bit          CLEAR_ON_LAST          = 1'b1
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic [15:0]                           gain,
   input  logic                                  s00_axis_tvalid,
   input  logic                                  s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   output logic                                  s00_axis_tready,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

   logic               en;
   logic signed [15:0] sample;
   logic signed [16:0] gain_s;
   logic signed [32:0] prod_next;

   logic               p1_valid;
   logic               p1_last;
   logic signed [32:0] p1_prod;

   logic [15:0]        inc;
   logic [15:0]        phase;
   logic [15:0]        phase_next;
   logic [31:0]        out_data;

   // reset port keeps its AXI name but is active-high here
   assign en              = m00_axis_tready || !m00_axis_tvalid;
   assign s00_axis_tready = en;

   assign sample    = s00_axis_tdata[15:0];
   assign gain_s    = {1'b0, gain};
   assign prod_next = sample * gain_s;

   // floor(prod / 256), truncated; overflow wraps silently
   assign inc        = p1_prod[23:8];
   assign phase_next = phase + inc;

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_aresetn) begin
         p1_valid <= 1'b0;
         p1_last  <= 1'b0;
         p1_prod  <= '0;
      end else if (en) begin
         p1_valid <= s00_axis_tvalid;
         p1_last  <= s00_axis_tlast;
         if (s00_axis_tvalid) begin
            p1_prod <= prod_next;
         end
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_aresetn) begin
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         out_data        <= '0;
         phase           <= '0;
      end else if (en) begin
         if (p1_valid) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= p1_last;
            out_data        <= {phase_next, MAGNITUDE};
            phase           <= (CLEAR_ON_LAST && p1_last) ? 16'h0000 : phase_next;
         end else begin
            m00_axis_tvalid <= 1'b0;
         end
      end
   end

   assign m00_axis_tdata = C_M00_AXIS_TDATA_WIDTH'(out_data);
   assign m00_axis_tstrb = '1;

   logic unused_bits;
   assign unused_bits = &{1'b0, s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16],
                          p1_prod[32:24], p1_prod[7:0]};

endmodule

// File: tb/tb_fm_modulate.sv
// Directed bench for fm_modulate: reset, ramp, wrap, fractional gain, backpressure, tlast clear.
module tb_fm_modulate;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] gain = 16'h0100;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic [31:0] s_data = '0;
   logic [3:0]  s_strb = '0;
   logic        s_ready;
   logic        m_ready = 1'b1;
   logic        m_valid;
   logic        m_last;
   logic [31:0] m_data;
   logic [3:0]  m_strb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fm_modulate dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst),
      .gain             (gain),
      .s00_axis_tvalid  (s_valid),
      .s00_axis_tlast   (s_last),
      .s00_axis_tdata   (s_data),
      .s00_axis_tstrb   (s_strb),
      .s00_axis_tready  (s_ready),
      .m00_axis_tready  (m_ready),
      .m00_axis_tvalid  (m_valid),
      .m00_axis_tlast   (m_last),
      .m00_axis_tdata   (m_data),
      .m00_axis_tstrb   (m_strb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // drive one input beat, clock once, then check the output register
   task automatic cyc(input string tag, input logic v, input logic [15:0] d, input logic l,
                      input logic exp_v, input logic [15:0] exp_ang, input logic exp_l);
      s_valid = v;
      s_data  = {16'hA5A5, d};
      s_last  = l;
      @(posedge clk); #1;
      chk({tag, "_tvalid"}, {31'd0, m_valid}, {31'd0, exp_v});
      if (exp_v) begin
         chk({tag, "_tdata"}, m_data, {exp_ang, 16'h4000});
         chk({tag, "_tlast"}, {31'd0, m_last}, {31'd0, exp_l});
      end
   endtask

   initial begin
      logic [15:0] model_phase;
      logic [31:0] prev_data;
      logic        prev_stall;
      logic        accepted;
      int          si;
      int          ei;

      // reset held with random inputs
      #1;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'($urandom);
         s_last  = 1'($urandom);
         s_data  = $urandom;
         m_ready = 1'($urandom);
         gain    = 16'($urandom);
         @(posedge clk); #1;
         chk("rst_tvalid", {31'd0, m_valid}, 32'd0);
         chk("rst_tdata", m_data, 32'd0);
         chk("rst_tlast", {31'd0, m_last}, 32'd0);
      end
      chk("tstrb", {28'd0, m_strb}, 32'h0000_000F);
      rst     = 1'b0;
      m_ready = 1'b1;
      gain    = 16'h0100;

      // ramp: first output equals first inc, two cycles after presentation
      cyc("ramp0", 1'b1, 16'd100, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("ramp_sready", {31'd0, s_ready}, 32'd1);
      cyc("ramp1", 1'b1, 16'd100, 1'b0, 1'b1, 16'h0064, 1'b0);
      cyc("ramp2", 1'b1, 16'd100, 1'b1, 1'b1, 16'h00C8, 1'b0);
      cyc("ramp3", 1'b0, 16'd0,   1'b0, 1'b1, 16'h012C, 1'b1);
      cyc("ramp4", 1'b0, 16'd0,   1'b0, 1'b0, 16'h0000, 1'b0);

      // wrap-around
      cyc("wrap0", 1'b1, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 1'b0);
      cyc("wrap1", 1'b1, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      cyc("wrap2", 1'b1, 16'h0003, 1'b1, 1'b1, 16'hFFFE, 1'b0);
      cyc("wrap3", 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1);
      cyc("wrap4", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

      // half gain: -3*0.5 floors to -2, 3*0.5 floors to 1
      gain = 16'h0080;
      cyc("neg0", 1'b1, 16'hFFFD, 1'b0, 1'b0, 16'h0000, 1'b0);
      cyc("neg1", 1'b1, 16'h0003, 1'b1, 1'b1, 16'hFFFE, 1'b0);
      gain = 16'h0100;
      cyc("neg2", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b1);
      cyc("neg3", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

      // backpressure: samples 1..8, output stalled for three cycles
      model_phase = 16'h0000;
      prev_stall  = 1'b0;
      prev_data   = '0;
      si = 0;
      ei = 0;
      for (int c = 0; c < 40; c++) begin
         if (si == 8 && ei == 8) break;
         m_ready = !(c >= 4 && c <= 6);
         s_valid = (si < 8);
         s_data  = 32'(si + 1);
         s_last  = (si == 7);
         #1;
         if (m_valid && !m_ready) chk("bp_sready", {31'd0, s_ready}, 32'd0);
         if (prev_stall) chk("bp_hold", m_data, prev_data);
         accepted = s_valid && s_ready;
         if (m_valid && m_ready) begin
            model_phase = model_phase + 16'(ei + 1);
            chk("bp_data", m_data, {model_phase, 16'h4000});
            ei++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         @(posedge clk); #1;
         if (accepted) si++;
      end
      chk("bp_count", 32'(ei), 32'd8);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // tlast clears the phase
      cyc("last0", 1'b1, 16'd10, 1'b0, 1'b0, 16'h0000, 1'b0);
      cyc("last1", 1'b1, 16'd10, 1'b1, 1'b1, 16'h000A, 1'b0);
      cyc("last2", 1'b1, 16'd10, 1'b0, 1'b1, 16'h0014, 1'b1);
      cyc("last3", 1'b1, 16'd5,  1'b0, 1'b1, 16'h000A, 1'b0);
      cyc("last4", 1'b1, 16'd5,  1'b0, 1'b1, 16'h000F, 1'b0);

      // mid-packet reset discards in-flight beats and clears phase
      rst = 1'b1;
      cyc("mrst0", 1'b1, 16'd5, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("mrst_tdata", m_data, 32'd0);
      rst = 1'b0;
      cyc("mrst1", 1'b1, 16'd7, 1'b1, 1'b0, 16'h0000, 1'b0);
      cyc("mrst2", 1'b0, 16'd0, 1'b0, 1'b1, 16'h0007, 1'b1);
      cyc("mrst3", 1'b0, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
